// File: rtl/uart_loader.sv
// uart_loader: UART boot loader that assembles framed images into 32-bit words for the upg_* write ports.
// Define UART_TX_ACK_EN to add an 8N1 transmitter returning 0x55 (good checksum) or 0xEE (bad checksum).
module uart_loader #(
  parameter int unsigned CLK_HZ      = 10_000_000,
  parameter int unsigned BAUD        = 128_000,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic        fpga_clk,
  input  logic        fpga_rst,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        upg_err_o
);
  localparam int unsigned CPB = CLK_HZ / BAUD;
  localparam int unsigned CW  = $clog2(CPB + 1);
  localparam int unsigned TW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  // ---------------- RX byte receiver ----------------
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic          byte_valid, frame_err;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (rx_state_q)
      R_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = R_START;
      end
      R_START: if (rx_cnt_q == CNT_HALF) begin
        // a start bit that is already high again at its centre is a glitch
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (rx_cnt_q == CNT_BIT) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
      end
      R_STOP: if (rx_cnt_q == CNT_BIT) begin
        rx_state_d = R_IDLE;
        byte_valid = rx_s2_q;
        frame_err  = !rx_s2_q;
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge fpga_clk or negedge fpga_rst) begin
    if (!fpga_rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_s1_q    <= rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  // ---------------- Frame parser ----------------
  typedef enum logic [2:0] {
    S_SYNC, S_TGT, S_CNT0, S_CNT1, S_DATA, S_CSUM
`ifdef UART_TX_ACK_EN
    , S_ACK
`endif
  } state_e;

  state_e        state_q, state_d;
  logic          tgt_q, tgt_d;
  logic [15:0]   n_q, n_d;
  logic [13:0]   idx_q, idx_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [23:0]   word_q, word_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          wen_q, wen_d;
  logic [14:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          in_ack;
  logic          tmo_run;

`ifdef UART_TX_ACK_EN
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_busy;
  assign in_ack = (state_q == S_ACK);
`else
  assign in_ack = 1'b0;
`endif

  assign tmo_run = (state_q != S_SYNC) && !in_ack;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    n_d     = n_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    csum_d  = csum_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    done_d  = done_q;
    wen_d   = 1'b0;
    err_d   = 1'b0;
    tmo_d   = (tmo_run && !byte_valid) ? tmo_q + 1'b1 : '0;
`ifdef UART_TX_ACK_EN
    tx_start = 1'b0;
    tx_byte  = 8'h55;
    if (in_ack && !tx_busy) state_d = S_SYNC;
`endif
    if (frame_err) begin
      err_d   = 1'b1;
      state_d = S_SYNC;
    end else if (byte_valid) begin
      unique case (state_q)
        S_SYNC: if (rx_sh_q == 8'hA5) begin
          state_d = S_TGT;
          done_d  = 1'b0;
          idx_d   = '0;
          bcnt_d  = '0;
          csum_d  = '0;
        end
        S_TGT: begin
          tgt_d   = rx_sh_q[0];
          state_d = S_CNT0;
        end
        S_CNT0: begin
          n_d[7:0] = rx_sh_q;
          state_d  = S_CNT1;
        end
        S_CNT1: begin
          n_d[15:8] = rx_sh_q;
          if ({rx_sh_q, n_q[7:0]} == 16'd0 || {rx_sh_q, n_q[7:0]} > 16'd16384) begin
            err_d   = 1'b1;
            state_d = S_SYNC;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          word_d = {rx_sh_q, word_q[23:8]};
          csum_d = csum_q ^ rx_sh_q;
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == 2'd3) begin
            wen_d = 1'b1;
            dat_d = {rx_sh_q, word_q};
            adr_d = {tgt_q, idx_q};
            idx_d = idx_q + 1'b1;
            if ({2'b00, idx_q} == n_q - 16'd1) state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          if (rx_sh_q == csum_q) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
`ifdef UART_TX_ACK_EN
          tx_byte  = (rx_sh_q == csum_q) ? 8'h55 : 8'hEE;
          tx_start = 1'b1;
          state_d  = S_ACK;
`else
          state_d  = S_SYNC;
`endif
        end
        default: ;
      endcase
    end else if (tmo_run && tmo_q == TMO_LAST) begin
      err_d   = 1'b1;
      tmo_d   = '0;
      state_d = S_SYNC;
    end
  end

  always_ff @(posedge fpga_clk or negedge fpga_rst) begin
    if (!fpga_rst) begin
      state_q <= S_SYNC;
      tgt_q   <= 1'b0;
      n_q     <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
      wen_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
      wen_q   <= wen_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = done_q;
  assign upg_err_o  = err_q;

  // ---------------- Optional ack transmitter ----------------
`ifdef UART_TX_ACK_EN
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;

  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_q, tx_d;

  assign tx_busy = (tx_state_q != T_IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_d       = tx_q;
    unique case (tx_state_q)
      T_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (tx_start) begin
          tx_sh_d    = tx_byte;
          tx_d       = 1'b0;
          tx_state_d = T_START;
        end
      end
      T_START: if (tx_cnt_q == CNT_BIT) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_d       = tx_sh_q[0];
        tx_sh_d    = {1'b0, tx_sh_q[7:1]};
        tx_state_d = T_DATA;
      end
      T_DATA: if (tx_cnt_q == CNT_BIT) begin
        tx_cnt_d = '0;
        tx_bit_d = tx_bit_q + 1'b1;
        if (tx_bit_q == 3'd7) begin
          tx_d       = 1'b1;
          tx_state_d = T_STOP;
        end else begin
          tx_d    = tx_sh_q[0];
          tx_sh_d = {1'b0, tx_sh_q[7:1]};
        end
      end
      T_STOP: if (tx_cnt_q == CNT_BIT) tx_state_d = T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge fpga_clk or negedge fpga_rst) begin
    if (!fpga_rst) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_q       <= tx_d;
    end
  end

  assign tx_o = tx_q;
`else
  assign tx_o = 1'b1;
`endif

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: randomized frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_loader;
  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 125_000;
  localparam int unsigned TMO    = 300;
  localparam int unsigned CPB    = CLK_HZ / BAUD;

  typedef logic [7:0] bytes_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        tx, wen, done, err;
  logic [14:0] adr;
  logic [31:0] dat;

  always #5 clk = ~clk;

  uart_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_CYC(TMO)) dut (
    .fpga_clk(clk), .fpga_rst(rst_n), .rx_i(rx), .tx_o(tx),
    .upg_wen_o(wen), .upg_adr_o(adr), .upg_dat_o(dat),
    .upg_done_o(done), .upg_err_o(err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [46:0] wr_log[$];
  logic [7:0]  tx_log[$];
  int          err_cnt = 0;
  int          tx_low  = 0;

  logic [31:0] words[$];
  bytes_t      frm;
  logic [46:0] exp_wr[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (wen) wr_log.push_back({adr, dat});
      if (err) err_cnt++;
      if (!tx) tx_low++;
    end
  end

`ifdef UART_TX_ACK_EN
  always begin
    logic [7:0] b;
    @(negedge tx);
    repeat (CPB / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx;
    end
    repeat (CPB) @(negedge clk);
    tx_log.push_back(b);
  end
`endif

  task automatic clear_logs();
    @(posedge clk);
    wr_log = {};
    tx_log = {};
    err_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_bytes(input bytes_t q, input int unsigned gap_max);
    foreach (q[i]) begin
      send_byte(q[i], 1'b1);
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
  endtask

  // Reference frame: header, LE words, XOR checksum; expected writes at {target, index}.
  function automatic void build_frame(input logic [7:0] tgt_byte, input logic good);
    logic [7:0]  cs;
    logic [7:0]  b;
    int unsigned n;
    cs = 8'h00;
    n  = words.size();
    frm = {};
    exp_wr = {};
    frm.push_back(8'hA5);
    frm.push_back(tgt_byte);
    frm.push_back(n[7:0]);
    frm.push_back(n[15:8]);
    foreach (words[i]) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'((words[i] >> (8 * k)) & 32'hFF);
        frm.push_back(b);
        cs = cs ^ b;
      end
      exp_wr.push_back({tgt_byte[0], 14'(i), words[i]});
    end
    frm.push_back(good ? cs : ~cs);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (wen !== 1'b0)  begin n_fail++; $display("FAIL reset_wen got %b want 0", wen); end
    n_tests++; if (adr !== 15'h0) begin n_fail++; $display("FAIL reset_adr got %h want 0", adr); end
    n_tests++; if (dat !== 32'h0) begin n_fail++; $display("FAIL reset_dat got %h want 0", dat); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (err !== 1'b0)  begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_tests++; if (tx !== 1'b1)   begin n_fail++; $display("FAIL reset_tx got %b want 1", tx); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_word();
    logic [46:0] got;
    clear_logs();
    send_bytes('{8'hA5, 8'h00, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08}, 10);
    repeat (5) @(negedge clk);
    got = (wr_log.size() > 0) ? wr_log[0] : 'x;
    n_tests++; if (wr_log.size() != 1) begin n_fail++; $display("FAIL s1_wcount got %0d want 1", wr_log.size()); end
    n_tests++; if (got !== {15'h0000, 32'h12345678}) begin n_fail++; $display("FAIL s1_write got %h want %h", got, {15'h0000, 32'h12345678}); end
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL s1_done got %b want 1", done); end
    n_tests++; if (err_cnt != 0) begin n_fail++; $display("FAIL s1_err got %0d want 0", err_cnt); end
`ifdef UART_TX_ACK_EN
    for (int i = 0; i < 300 && tx_log.size() == 0; i++) @(negedge clk);
    n_tests++; if (tx_log.size() != 1 || tx_log[0] !== 8'h55) begin n_fail++; $display("FAIL s1_ack got %0d bytes want one 55", tx_log.size()); end
`endif
    repeat (12 * CPB) @(negedge clk);
  endtask

  task automatic test_two_words_ram();
    clear_logs();
    words = '{32'hDEADBEEF, 32'h00000001};
    build_frame(8'h01, 1'b1);
    send_bytes(frm, 10);
    repeat (5) @(negedge clk);
    n_tests++; if (wr_log.size() != 2) begin n_fail++; $display("FAIL s2_wcount got %0d want 2", wr_log.size()); end
    for (int i = 0; i < 2 && i < wr_log.size(); i++) begin
      n_tests++; if (wr_log[i] !== exp_wr[i]) begin n_fail++; $display("FAIL s2_write%0d got %h want %h", i, wr_log[i], exp_wr[i]); end
    end
    n_tests++; if (wr_log.size() == 2 && wr_log[1][46:32] !== 15'h4001) begin n_fail++; $display("FAIL s2_adr got %h want 4001", wr_log[1][46:32]); end
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL s2_done got %b want 1", done); end
    repeat (12 * CPB) @(negedge clk);
  endtask

  task automatic test_bad_csum();
    logic [46:0] got;
    clear_logs();
    send_bytes('{8'hA5, 8'h00, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09}, 10);
    repeat (5) @(negedge clk);
    got = (wr_log.size() > 0) ? wr_log[0] : 'x;
    n_tests++; if (wr_log.size() != 1 || got !== {15'h0000, 32'h12345678}) begin n_fail++; $display("FAIL s3_write got %0d writes first %h", wr_log.size(), got); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL s3_done got %b want 0", done); end
    n_tests++; if (err_cnt != 1) begin n_fail++; $display("FAIL s3_err got %0d want 1", err_cnt); end
`ifdef UART_TX_ACK_EN
    for (int i = 0; i < 300 && tx_log.size() == 0; i++) @(negedge clk);
    n_tests++; if (tx_log.size() != 1 || tx_log[0] !== 8'hEE) begin n_fail++; $display("FAIL s3_ack got %0d bytes want one EE", tx_log.size()); end
`endif
    repeat (12 * CPB) @(negedge clk);
  endtask

  task automatic test_count_limits();
    clear_logs();
    send_bytes('{8'hA5, 8'h00, 8'h00, 8'h00}, 5);
    repeat (5) @(negedge clk);
    n_tests++; if (err_cnt != 1 || wr_log.size() != 0) begin n_fail++; $display("FAIL n0_err got err %0d writes %0d want 1/0", err_cnt, wr_log.size()); end
    send_bytes('{8'h11}, 5);
    repeat (5) @(negedge clk);
    n_tests++; if (err_cnt != 1 || wr_log.size() != 0) begin n_fail++; $display("FAIL sync_ignore got err %0d writes %0d want 1/0", err_cnt, wr_log.size()); end
    clear_logs();
    words = '{$urandom()};
    build_frame(8'h00, 1'b1);
    send_bytes(frm, 10);
    repeat (5) @(negedge clk);
    n_tests++; if (wr_log.size() != 1 || wr_log[0] !== exp_wr[0] || done !== 1'b1) begin n_fail++; $display("FAIL n0_recover got %0d writes done %b want 1/1", wr_log.size(), done); end
    repeat (12 * CPB) @(negedge clk);
    clear_logs();
    send_bytes('{8'hA5, 8'h00, 8'h01, 8'h40}, 5);
    repeat (5) @(negedge clk);
    n_tests++; if (err_cnt != 1 || done !== 1'b0) begin n_fail++; $display("FAIL n16385 got err %0d done %b want 1/0", err_cnt, done); end
    // N = 16384 is legal: one word lands, then the missing bytes time out
    clear_logs();
    send_bytes('{8'hA5, 8'h00, 8'h00, 8'h40, 8'h44, 8'h33, 8'h22, 8'h11}, 5);
    repeat (5) @(negedge clk);
    n_tests++; if (err_cnt != 0 || wr_log.size() != 1) begin n_fail++; $display("FAIL n16384_accept got err %0d writes %0d want 0/1", err_cnt, wr_log.size()); end
    repeat (TMO + 50) @(negedge clk);
    n_tests++; if (err_cnt != 1 || wr_log.size() != 1 || wr_log[0] !== {15'h0000, 32'h11223344}) begin n_fail++; $display("FAIL n16384_tmo got err %0d writes %0d want 1/1", err_cnt, wr_log.size()); end
  endtask

  task automatic test_framing_timeout();
    clear_logs();
    send_bytes('{8'hA5, 8'h00, 8'h01, 8'h00, 8'h78}, 5);
    send_byte(8'h56, 1'b0);
    repeat (20) @(negedge clk);
    n_tests++; if (err_cnt != 1 || wr_log.size() != 0 || done !== 1'b0) begin n_fail++; $display("FAIL framing got err %0d writes %0d done %b want 1/0/0", err_cnt, wr_log.size(), done); end
    repeat (TMO + 50) @(negedge clk);
    n_tests++; if (err_cnt != 1) begin n_fail++; $display("FAIL framing_sync got err %0d want 1", err_cnt); end
    clear_logs();
    send_bytes('{8'hA5, 8'h00, 8'h01, 8'h00, 8'h78}, 5);
    repeat (TMO + 50) @(negedge clk);
    n_tests++; if (err_cnt != 1 || wr_log.size() != 0) begin n_fail++; $display("FAIL timeout got err %0d writes %0d want 1/0", err_cnt, wr_log.size()); end
    clear_logs();
    words = '{$urandom()};
    build_frame(8'h03, 1'b1);
    send_bytes(frm, 10);
    repeat (5) @(negedge clk);
    n_tests++; if (wr_log.size() != 1 || wr_log[0] !== exp_wr[0] || done !== 1'b1) begin n_fail++; $display("FAIL timeout_recover got %0d writes done %b want 1/1", wr_log.size(), done); end
    repeat (12 * CPB) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    clear_logs();
    send_bytes('{8'hA5, 8'h01, 8'h01, 8'h00, 8'hAA, 8'hBB}, 5);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (wen !== 1'b0 || adr !== 15'h0 || dat !== 32'h0) begin n_fail++; $display("FAIL midrst_regs got wen %b adr %h dat %h want 0", wen, adr, dat); end
    n_tests++; if (done !== 1'b0 || err !== 1'b0 || tx !== 1'b1) begin n_fail++; $display("FAIL midrst_flags got done %b err %b tx %b want 0/0/1", done, err, tx); end
    rst_n = 1'b1;
    send_bytes('{8'hCC, 8'hDD}, 5);
    repeat (5) @(negedge clk);
    n_tests++; if (wr_log.size() != 0) begin n_fail++; $display("FAIL midrst_nowrite got %0d writes want 0", wr_log.size()); end
    words = '{$urandom(), $urandom()};
    build_frame(8'h00, 1'b1);
    send_bytes(frm, 10);
    repeat (5) @(negedge clk);
    n_tests++; if (wr_log.size() != 2 || wr_log[0] !== exp_wr[0] || wr_log[1] !== exp_wr[1] || done !== 1'b1) begin n_fail++; $display("FAIL midrst_reload got %0d writes done %b want 2/1", wr_log.size(), done); end
    repeat (12 * CPB) @(negedge clk);
  endtask

  task automatic test_random_frames();
    logic       good;
    logic [7:0] tb;
    for (int f = 0; f < 4; f++) begin
      clear_logs();
      words = {};
      for (int w = 0; w < int'($urandom_range(1, 4)); w++) words.push_back($urandom());
      good = ($urandom_range(0, 3) != 0);
      tb   = 8'($urandom());
      build_frame(tb, good);
      send_bytes(frm, (f % 2 == 0) ? 0 : 20);
      repeat (5) @(negedge clk);
      n_tests++; if (wr_log.size() != exp_wr.size()) begin n_fail++; $display("FAIL rnd%0d_wcount got %0d want %0d", f, wr_log.size(), exp_wr.size()); end
      for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) begin
        n_tests++; if (wr_log[i] !== exp_wr[i]) begin n_fail++; $display("FAIL rnd%0d_write%0d got %h want %h", f, i, wr_log[i], exp_wr[i]); end
      end
      n_tests++; if (done !== good) begin n_fail++; $display("FAIL rnd%0d_done got %b want %b", f, done, good); end
      n_tests++; if (err_cnt != (good ? 0 : 1)) begin n_fail++; $display("FAIL rnd%0d_err got %0d want %0d", f, err_cnt, good ? 0 : 1); end
`ifdef UART_TX_ACK_EN
      for (int i = 0; i < 300 && tx_log.size() == 0; i++) @(negedge clk);
      n_tests++; if (tx_log.size() != 1 || tx_log[0] !== (good ? 8'h55 : 8'hEE)) begin n_fail++; $display("FAIL rnd%0d_ack got %0d bytes", f, tx_log.size()); end
`endif
      repeat (12 * CPB) @(negedge clk);
    end
`ifndef UART_TX_ACK_EN
    n_tests++; if (tx_low != 0) begin n_fail++; $display("FAIL tx_idle got %0d low cycles want 0", tx_low); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_words_ram();
    test_bad_csum();
    test_count_limits();
    test_framing_timeout();
    test_reset_midframe();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
